// File: rtl/calc_pkg.sv
// Shared types and helpers for the sequential calculator core.
//   calc_state_t : core FSM states
//   calc_op_t    : operation encoding handed to the iterative unit
//   cnt_width()  : width of an iteration counter able to hold 0..w
package calc_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        IDLE = 2'd1,
        MUL  = 2'd2,
        DIV  = 2'd3
    } calc_state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } calc_op_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// Iterative multiply / divide datapath, one step per clock.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : capture a, b and op, begin iterating on the next edge
//   abort      : drop any iteration in progress
//   op         : OP_MUL (shift-add) or OP_DIV (restoring division)
//   a, b       : unsigned operands (multiplicand/multiplier, dividend/divisor)
//   result     : value produced by the current step; valid when last=1
//                (div: {remainder, quotient})
//   last       : high during the cycle whose closing edge completes step W
module calc_iter_unit
    import calc_pkg::*;
#(
    parameter int W = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  calc_op_t       op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] result,
    output logic           last
);

    localparam int CW = cnt_width(W);

    logic            active;
    logic            is_div;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  acc;    // mul: {partial product, remaining multiplier}; div: {remainder, quotient}
    logic [W-1:0]    opnd;   // mul: multiplicand; div: divisor

    logic [W:0]      mul_sum;
    logic [2*W:0]    mul_wide;
    logic [W:0]      div_shift;
    logic [W:0]      div_diff;
    logic            div_ge;
    logic [2*W-1:0]  acc_next;

    // NOTE: every combinational output gets a default first, so no path
    // through this block can leave a value unassigned and infer a latch.
    always_comb begin
        acc_next  = acc;
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_wide  = {mul_sum, acc[W-1:0]};
        div_shift = {acc[2*W-1:W], acc[W-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = (div_shift >= {1'b0, opnd});
        if (is_div) begin
            acc_next = {(div_ge ? W'(div_diff) : W'(div_shift)),
                        W'({acc[W-1:0], div_ge})};
        end else begin
            acc_next = (2*W)'(mul_wide >> 1);
        end
    end

    assign result = acc_next;
    assign last   = active && (cnt == CW'(W - 1));

    // NOTE: acc and opnd are pure datapath and are loaded on start, so they
    // carry no reset; only the control state that gates them is reset.
    always_ff @(posedge clk) begin
        if (start) begin
            is_div <= (op == OP_DIV);
            opnd   <= (op == OP_DIV) ? b : a;
            acc    <= {{W{1'b0}}, (op == OP_DIV) ? a : b};
        end else if (active) begin
            acc <= acc_next;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
        end else if (active) begin
            cnt <= cnt + 1'b1;
            if (last) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/calc_core_seq.sv
// Sequential push-button calculator core.
//   clk, rst_n   : clock, synchronous active-low reset
//   A, B         : unsigned W-bit operands, captured when a request is accepted
//   b_lig        : power toggle button (rising-edge detected)
//   b_soma/b_sub/b_multi/b_div : operation buttons (rising-edge detected)
//   sensorIR     : user presence; new requests are accepted only while high
//   Y, sinal     : result magnitude and sign (1 = negative)
//   EN           : powered on (display enable)
//   busy         : multiply/divide iteration in progress
//   done         : one-cycle pulse after Y is written
//   err          : divide by zero, held until next accepted op or power-off
module calc_core_seq
    import calc_pkg::*;
#(
    parameter int W = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic           b_lig,
    input  logic           b_soma,
    input  logic           b_sub,
    input  logic           b_multi,
    input  logic           b_div,
    input  logic           sensorIR,
    output logic [2*W-1:0] Y,
    output logic           sinal,
    output logic           EN,
    output logic           busy,
    output logic           done,
    output logic           err
);

    calc_state_t    state;
    logic           lig_q, soma_q, sub_q, multi_q, div_q;
    logic           lig_p, soma_p, sub_p, multi_p, div_p;
    logic           accept;
    logic           iter_start;
    calc_op_t       iter_op;
    logic [2*W-1:0] iter_result;
    logic           iter_last;

    assign lig_p   = b_lig   & ~lig_q;
    assign soma_p  = b_soma  & ~soma_q;
    assign sub_p   = b_sub   & ~sub_q;
    assign multi_p = b_multi & ~multi_q;
    assign div_p   = b_div   & ~div_q;

    // A power press wins over any operation press on the same edge.
    assign accept     = (state == IDLE) && sensorIR && !lig_p;
    assign iter_start = accept && !soma_p && !sub_p &&
                        (multi_p || (div_p && (B != '0)));
    assign iter_op    = multi_p ? OP_MUL : OP_DIV;

    calc_iter_unit #(.W(W)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (iter_start),
        .abort  (lig_p),
        .op     (iter_op),
        .a      (A),
        .b      (B),
        .result (iter_result),
        .last   (iter_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= OFF;
            Y       <= '0;
            sinal   <= 1'b0;
            EN      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            lig_q   <= 1'b0;
            soma_q  <= 1'b0;
            sub_q   <= 1'b0;
            multi_q <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            lig_q   <= b_lig;
            soma_q  <= b_soma;
            sub_q   <= b_sub;
            multi_q <= b_multi;
            div_q   <= b_div;
            done    <= 1'b0;

            if (lig_p) begin
                if (state == OFF) begin
                    state <= IDLE;
                    EN    <= 1'b1;
                end else begin
                    state <= OFF;
                    EN    <= 1'b0;
                    Y     <= '0;
                    sinal <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            if (soma_p) begin
                                Y     <= (2*W)'(A) + (2*W)'(B);
                                sinal <= 1'b0;
                                err   <= 1'b0;
                                done  <= 1'b1;
                            end else if (sub_p) begin
                                // Sign-magnitude result: subtract the smaller from the larger.
                                Y     <= (A >= B) ? (2*W)'(A - B) : (2*W)'(B - A);
                                sinal <= (A < B);
                                err   <= 1'b0;
                                done  <= 1'b1;
                            end else if (multi_p) begin
                                state <= MUL;
                                busy  <= 1'b1;
                                err   <= 1'b0;
                            end else if (div_p) begin
                                if (B == '0) begin
                                    Y     <= '1;
                                    sinal <= 1'b0;
                                    err   <= 1'b1;
                                    done  <= 1'b1;
                                end else begin
                                    state <= DIV;
                                    busy  <= 1'b1;
                                    err   <= 1'b0;
                                end
                            end
                        end
                    end
                    MUL, DIV: begin
                        if (iter_last) begin
                            state <= IDLE;
                            Y     <= iter_result;
                            sinal <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/calc_core_seq.md
# calc_core_seq

Parametrised sequential arithmetic core for the push-button calculator. It replaces the fixed 7-bit combinational calculator with a W-bit unit that adds power toggle, IR presence gating and edge-detected buttons. Multiply and divide run on an iterative datapath, and the core reports busy, done and error status. It sits between the board buttons and switches and the 7-segment decoders, which consume `Y`, `sinal` and `EN`.

## Interface
- `W`, default 7: operand width; result width is 2W.
- `clk` input 1: system clock; all state changes on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `A` input W: operand A, unsigned.
- `B` input W: operand B, unsigned.
- `b_lig` input 1: power toggle button, level, rising-edge detected.
- `b_soma` input 1: add request button.
- `b_sub` input 1: subtract request button.
- `b_multi` input 1: multiply request button.
- `b_div` input 1: divide request button.
- `sensorIR` input 1: presence sensor; high means the user is present.
- `Y` output 2W: result magnitude.
- `sinal` output 1: result sign; 1 means negative.
- `EN` output 1: powered on; the decoders blank when it is low.
- `busy` output 1: multiply or divide iteration in progress.
- `done` output 1: one-cycle pulse when `Y` is updated.
- `err` output 1: divide by zero.

## Operation
- **Button edge detection.** Every button has a previous-value register.
  - A press is accepted on an edge where the button is 1 and its previous value is 0.
  - Holding a button gives exactly one press.
- **States:** OFF, IDLE, MUL, DIV.
  - OFF → IDLE on a `b_lig` press.
  - IDLE, MUL or DIV → OFF on a `b_lig` press. This aborts any iteration and clears `Y`, `sinal` and `err`.
- **Request gating.** Operation requests are accepted only in IDLE with `sensorIR`=1. All other requests are dropped, not queued.
- **Simultaneous requests:** priority is soma > sub > multi > div. `b_lig` overrides all of them.
- **Add:** `Y` = zero-extended A + B; `sinal`=0.
- **Subtract:** if A ≥ B, `Y` = A − B and `sinal`=0. Otherwise `Y` = B − A and `sinal`=1 (sign-magnitude).
- **Multiply:** shift-add over W iterations; `Y` = A·B (fits in 2W bits); `sinal`=0.
- **Divide:** restoring division over W iterations.
  - `Y[W-1:0]` = quotient; `Y[2W-1:W]` = remainder; `sinal`=0.
  - If B = 0: no iteration, `Y` = all ones, `err`=1.
- **Operand capture.** Operands are captured on acceptance. Changes on A or B during MUL or DIV do not affect the result.
- **Error flag.** `err` stays set until the next accepted operation, a power-off or a reset.
- **Output stability.** `Y` and `sinal` hold their last result until the next completion, power-off or reset.

## Timing
- **Reset:** state OFF; `Y`=0, `sinal`=0, `EN`=0, `busy`=0, `done`=0, `err`=0. Button previous-value registers are cleared to 0.
  - A button held high through reset therefore registers as a press on the first edge after reset.
  - Reset in the middle of an operation discards it, with no `done`.
- **`EN`:** 1 in every state except OFF. It changes on the same edge as the state change.
- **Add, subtract and divide by zero:** `Y`, `sinal` and `err` update on the acceptance edge. `done`=1 for the following cycle only; `busy` stays 0.
- **Multiply and divide:** acceptance at edge t.
  - `busy`=1 from edge t through edge t+W.
  - `Y` is written at edge t+W, and the core returns to IDLE.
  - `done`=1 during the cycle after edge t+W.
- **Back-to-back operation:** a new request can be accepted on the edge right after completion, provided it is a fresh rising edge.
- **`sensorIR`:** falling during MUL or DIV does not abort; it only gates new requests.

## Structure
- **Package `calc_pkg`:**
  - state enum `calc_state_t` {OFF, IDLE, MUL, DIV};
  - op encoding `calc_op_t` {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
  - iteration counter width function `$clog2(W+1)`.
- **Sub-module `calc_iter_unit`** (parametrised by W) holds the shift-add / restoring datapath.
  - Inputs: start, op, operands.
  - Outputs: result, last-iteration strobe.
- **Top-level core** owns edge detection, the FSM, the output registers and the add/subtract logic.

## Test plan
- W=7, reset then a `b_lig` press → `EN`=1 the next cycle. A second press → `EN`=0 and `Y`=0.
- A=100, B=27, `b_sub` press → `Y`=73, `sinal`=0, `done` for 1 cycle. Swap the operands → `Y`=73, `sinal`=1.
- A=127, B=127, `b_multi` press → `busy` for 7 cycles, then `Y`=16129 and `done`. `b_soma` pressed while `busy` is ignored.
- A=100, B=7, `b_div` → quotient 14 and remainder 2, i.e. `Y` = (2<<7)|14 = 270. B=0 → `Y`=16383, `err`=1, then `b_soma` clears `err`.
- `sensorIR`=0 with `b_soma` pressed → no `done` and `Y` unchanged. Held `b_soma` with `sensorIR` rising later → no operation until a new press.
- `b_lig` during MUL at iteration 3 → OFF, `Y`=0, no `done`. Repeat with `rst_n`=0 mid-DIV → all outputs at reset values on the next edge.
